// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D single-port SRAM arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_MAX_STARVE = 4;
   localparam int STRB_W         = DEF_DATA_W / 8;

   // Clears the two byte-offset bits so the SRAM always sees a word address.
   localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

   // Which requester owns the single access currently in flight.
   typedef enum logic [1:0] {
      OWNER_NONE = 2'b00,
      OWNER_IF   = 2'b01,
      OWNER_D    = 2'b10
   } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants taken while fetch is waiting; once it
// saturates at MAX_STARVE, force_if hands the next grant to fetch.
module arb_starve_counter #(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic force_if
);

   localparam int CNT_W = $clog2(MAX_STARVE + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise saturating increment.
   always_comb begin
      // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_W'(MAX_STARVE))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_if = (cnt_q == CNT_W'(MAX_STARVE));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch (IF) and the memory
// stage (D). Data wins by default, with a starvation guard for fetch. Only
// one access is ever in flight; its 1-cycle response is steered back to the
// recorded owner, and a flush can squash an in-flight fetch response.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MAX_STARVE = DEF_MAX_STARVE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   input  logic                if_flush,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,
   input  logic                d_req_valid,
   input  logic                d_req_we,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_strb,
   output logic                d_req_ready,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                sram_en,
   output logic [DATA_W/8-1:0] sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata,
   output logic                busy
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = WORD_ALIGN_MASK[ADDR_W-1:0];

   logic   grant_d;
   logic   grant_if;
   logic   force_if;
   owner_e rsp_owner_q;
   owner_e rsp_owner_d;
   logic   rsp_is_store_q;
   logic   rsp_is_store_d;
   logic   flush_pending_q;
   logic   flush_pending_d;

   // Data first, unless fetch has waited through MAX_STARVE data grants.
   assign grant_d  = d_req_valid && !(if_req_valid && force_if);
   assign grant_if = if_req_valid && !grant_d;

   arb_starve_counter #(
      .MAX_STARVE (MAX_STARVE)
   ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (grant_d && if_req_valid),
      .clr      (grant_if || !if_req_valid),
      .force_if (force_if)
   );

   // State register: owner of the in-flight access and the flush marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_owner_q     <= OWNER_NONE;
         rsp_is_store_q  <= 1'b0;
         flush_pending_q <= 1'b0;
      end else begin
         rsp_owner_q     <= rsp_owner_d;
         rsp_is_store_q  <= rsp_is_store_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   // Next state: record this cycle's grant; a flush marks any fetch issued so far.
   always_comb begin
      rsp_owner_d     = OWNER_NONE;
      rsp_is_store_d  = 1'b0;
      flush_pending_d = if_flush && (grant_if || (rsp_owner_q == OWNER_IF));
      if (grant_d) begin
         rsp_owner_d    = OWNER_D;
         rsp_is_store_d = d_req_we;
      end else if (grant_if) begin
         rsp_owner_d = OWNER_IF;
      end
   end

   // Request side: handshakes and SRAM drive for the winning requester.
   always_comb begin
      if_req_ready = grant_if;
      d_req_ready  = grant_d;
      sram_en      = grant_d || grant_if;
      sram_we      = '0;
      sram_addr    = '0;
      sram_wdata   = '0;
      if (grant_d) begin
         sram_addr  = d_req_addr & ALIGN_MASK;
         sram_we    = d_req_we ? d_req_strb : '0;
         sram_wdata = d_req_wdata;
      end else if (grant_if) begin
         sram_addr = if_req_addr & ALIGN_MASK;
      end
   end

   // Response side: steer SRAM read data to the owner recorded last cycle.
   always_comb begin
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      d_rsp_valid  = 1'b0;
      d_rsp_data   = '0;
      busy         = (rsp_owner_q != OWNER_NONE);
      case (rsp_owner_q)
         OWNER_IF: begin
            if_rsp_valid = !flush_pending_q;
            if_rsp_data  = sram_rdata;
         end
         OWNER_D: begin
            d_rsp_valid = 1'b1;
            d_rsp_data  = rsp_is_store_q ? '0 : sram_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an SRAM model answers accesses, and a
// scoreboard queue holds the response expected one cycle after each grant.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_flush;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        d_req_valid;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_strb;
   logic        d_req_ready;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_addr  (if_req_addr),
      .if_req_ready (if_req_ready),
      .if_flush     (if_flush),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .d_req_valid  (d_req_valid),
      .d_req_we     (d_req_we),
      .d_req_addr   (d_req_addr),
      .d_req_wdata  (d_req_wdata),
      .d_req_strb   (d_req_strb),
      .d_req_ready  (d_req_ready),
      .d_rsp_valid  (d_rsp_valid),
      .d_rsp_data   (d_rsp_data),
      .sram_en      (sram_en),
      .sram_we      (sram_we),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .busy         (busy)
   );

   // Power-on SRAM contents.
   function automatic logic [31:0] init_word(input logic [7:0] idx);
      case (idx)
         8'h00:   return 32'h0000_0011;
         8'h01:   return 32'h0000_0022;
         8'h10:   return 32'hCAFE_0000;
         8'h40:   return 32'h1234_5678;
         default: return {8'h5A, idx, 8'hC3, idx};
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // SRAM model: 1-cycle read latency, byte-enabled writes.
   logic [31:0] sram_mem [0:255];
   bit          sram_written [0:255];

   function automatic logic [31:0] sram_word(input logic [7:0] idx);
      return sram_written[idx] ? sram_mem[idx] : init_word(idx);
   endfunction

   always @(posedge clk) begin
      if (sram_en) begin
         sram_rdata <= sram_word(sram_addr[9:2]);
         if (|sram_we) begin
            sram_mem[sram_addr[9:2]]     <= merge(sram_word(sram_addr[9:2]), sram_wdata, sram_we);
            sram_written[sram_addr[9:2]] <= 1'b1;
         end
      end
   end

   // Reference memory used to predict read data.
   logic [31:0] ref_mem [0:255];
   bit          ref_written [0:255];

   function automatic logic [31:0] ref_read(input logic [7:0] idx);
      return ref_written[idx] ? ref_mem[idx] : init_word(idx);
   endfunction

   typedef enum {E_NONE, E_IF, E_IF_KILLED, E_D} exp_kind_e;
   typedef struct {
      exp_kind_e   kind;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Compare the response outputs against the oldest scoreboard entry.
   task automatic check_rsp(input string tag);
      exp_t e;
      if (sb.size() == 0) e = '{E_NONE, 32'h0};
      else e = sb.pop_front();
      check($sformatf("%s/busy", tag), {31'h0, busy}, {31'h0, e.kind != E_NONE});
      check($sformatf("%s/if_rsp_valid", tag), {31'h0, if_rsp_valid}, {31'h0, e.kind == E_IF});
      check($sformatf("%s/d_rsp_valid", tag), {31'h0, d_rsp_valid}, {31'h0, e.kind == E_D});
      if (e.kind == E_IF) check($sformatf("%s/if_rsp_data", tag), if_rsp_data, e.data);
      if (e.kind == E_D) check($sformatf("%s/d_rsp_data", tag), d_rsp_data, e.data);
   endtask

   // One clock cycle: check last cycle's response, drive requests, check grant.
   task automatic step(input string tag,
                       input logic ifv, input logic [31:0] ifa, input logic fl,
                       input logic dv, input logic dwe, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic exp_ifr, input logic exp_dr);
      exp_t e;
      @(negedge clk);
      check_rsp(tag);
      if_req_valid = ifv;
      if_req_addr  = ifa;
      if_flush     = fl;
      d_req_valid  = dv;
      d_req_we     = dwe;
      d_req_addr   = da;
      d_req_wdata  = wd;
      d_req_strb   = st;
      #1;
      check($sformatf("%s/if_req_ready", tag), {31'h0, if_req_ready}, {31'h0, exp_ifr});
      check($sformatf("%s/d_req_ready", tag), {31'h0, d_req_ready}, {31'h0, exp_dr});
      check($sformatf("%s/sram_en", tag), {31'h0, sram_en}, {31'h0, exp_ifr | exp_dr});
      e = '{E_NONE, 32'h0};
      if (exp_dr) begin
         check($sformatf("%s/sram_addr", tag), sram_addr, {da[31:2], 2'b00});
         check($sformatf("%s/sram_we", tag), {28'h0, sram_we}, {28'h0, dwe ? st : 4'h0});
         e.kind = E_D;
         if (dwe) begin
            check($sformatf("%s/sram_wdata", tag), sram_wdata, wd);
            ref_mem[da[9:2]]     = merge(ref_read(da[9:2]), wd, st);
            ref_written[da[9:2]] = 1'b1;
         end else begin
            e.data = ref_read(da[9:2]);
         end
      end else if (exp_ifr) begin
         check($sformatf("%s/sram_addr", tag), sram_addr, {ifa[31:2], 2'b00});
         check($sformatf("%s/sram_we", tag), {28'h0, sram_we}, 32'h0);
         e.kind = fl ? E_IF_KILLED : E_IF;
         e.data = ref_read(ifa[9:2]);
      end
      sb.push_back(e);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      int nif;
      rst_n        = 1'b0;
      if_req_valid = 1'b0;
      if_req_addr  = '0;
      if_flush     = 1'b0;
      d_req_valid  = 1'b0;
      d_req_we     = 1'b0;
      d_req_addr   = '0;
      d_req_wdata  = '0;
      d_req_strb   = '0;

      // Reset state
      #12;
      check("rst/busy", {31'h0, busy}, 32'h0);
      check("rst/if_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
      check("rst/d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
      check("rst/if_rsp_data", if_rsp_data, 32'h0);
      check("rst/d_rsp_data", d_rsp_data, 32'h0);
      check("rst/sram_en", {31'h0, sram_en}, 32'h0);
      check("rst/readies", {30'h0, if_req_ready, d_req_ready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: back-to-back fetches
      step("t1a", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      step("t1b", 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      idle("t1c");
      idle("t1d");

      // 2: data load beats a simultaneous fetch; fetch granted next cycle
      step("t2a", 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
      step("t2b", 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      idle("t2c");

      // 3: starvation guard, expected grants D,D,D,D,IF,D,D,D,D,IF
      nif = 0;
      for (int i = 0; i < 10; i++) begin
         logic exp_if;
         exp_if = (i == 4) || (i == 9);
         step($sformatf("t3_%0d", i), 1'b1, 32'h20 + 32'(4 * nif), 1'b0,
              1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'h0, 4'h0, exp_if, !exp_if);
         if (exp_if) nif++;
      end
      idle("t3_end");

      // 4: partial store then reload of the same word
      step("t4a", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h102, 32'hAABB_AABB, 4'b1100, 1'b0, 1'b1);
      idle("t4b");
      step("t4c", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
      idle("t4d");
      idle("t4e");

      // 5: flush in the grant cycle kills that fetch only
      step("t5a", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      step("t5b", 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      idle("t5c");
      idle("t5d");

      // 6: reset while a load is in flight
      step("t6a", 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
      step("t6b", 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b1);
      step("t6c", 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
      rst_n        = 1'b0;
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t6/busy_after_rst", {31'h0, busy}, 32'h0);
      check("t6/d_rsp_valid_after_rst", {31'h0, d_rsp_valid}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step($sformatf("t6_post%0d", i), 1'b1, 32'h8, 1'b0,
              1'b1, 1'b0, 32'h40, 32'h0, 4'h0, i == 4, i != 4);
      end
      idle("t6_end0");
      idle("t6_end1");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port data/instruction SRAM between two requesters: the instruction-fetch stage (IF) and the memory stage (D, loads and stores).
- Sits between the pipeline stages and the SRAM macro.
- Makes at most one grant per cycle, using data-first priority with a starvation guard for fetch.
- Tracks the owner of the single in-flight access and routes the 1-cycle-latency response back to that owner, with a flush that squashes an in-flight fetch.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_STARVE, 4, maximum consecutive D grants while IF is waiting before IF is forced a grant.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_req_ready  out  1  fetch granted this cycle.
- if_flush  in  1  squash the fetch response currently in flight.
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse).
- if_rsp_data  out  DATA_W  fetched word.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_W  data byte address.
- d_req_wdata  in  DATA_W  store data, already lane-replicated.
- d_req_strb  in  DATA_W/8  byte enables for a store.
- d_req_ready  out  1  data request granted this cycle.
- d_rsp_valid  out  1  load data / store acknowledge (1-cycle pulse).
- d_rsp_data  out  DATA_W  load word; 0 for a store acknowledge.
- sram_en  out  1  SRAM access enable.
- sram_we  out  DATA_W/8  per-byte write enables; 0 for a read.
- sram_addr  out  ADDR_W  word-aligned address (bits [1:0] forced to 0).
- sram_wdata  out  DATA_W  write data.
- sram_rdata  in  DATA_W  read data; valid the cycle after sram_en.
- busy  out  1  a response is in flight.

Behaviour:
- Reset (asynchronous): all registered state cleared:
  - rsp_owner = NONE;
  - starve_cnt = 0;
  - flush_pending = 0.
- Reset outputs:
  - if_rsp_valid, d_rsp_valid, busy = 0;
  - if_rsp_data, d_rsp_data = 0;
  - readies and SRAM outputs = 0 whenever no request is valid.
- Grant logic is combinational in the current cycle:
  - grant_d = d_req_valid && !(if_req_valid && starve_cnt == MAX_STARVE);
  - grant_if = if_req_valid && !grant_d;
  - if_req_ready = grant_if; d_req_ready = grant_d.
  - Requesters hold valid and payload stable until ready. No request valid → sram_en = 0.
- SRAM drive on a grant:
  - sram_en = 1;
  - sram_addr = {addr[ADDR_W-1:2], 2'b00};
  - sram_we = d_req_strb if grant_d && d_req_we, else 0;
  - sram_wdata = d_req_wdata.
- rsp_owner register:
  - next value = IF, D or NONE from this cycle's grant;
  - latches d_req_we into rsp_is_store.
- Responses are driven in cycle N+1 from rsp_owner:
  - owner IF: if_rsp_valid = !flush_pending; if_rsp_data = sram_rdata.
  - owner D, load: d_rsp_valid = 1; d_rsp_data = sram_rdata.
  - owner D, store: d_rsp_valid = 1; d_rsp_data = 0.
  - Responses have no backpressure; the receiving stage must accept them.
- Throughput: fully pipelined. A new grant may issue in the same cycle a previous response returns, so back-to-back accesses achieve 1 access/cycle.
- busy = (rsp_owner != NONE).
- Flush:
  - flush_pending is set when if_flush is asserted while rsp_owner == IF, or while grant_if is high in the same cycle.
  - flush_pending clears after the suppressed response cycle.
  - if_flush asserted in cycle N kills only the fetch issued in cycle N or earlier; a fetch granted in cycle N+1 is delivered normally.
- Starvation counter:
  - increments on grant_d while if_req_valid is high, saturating at MAX_STARVE;
  - cleared on grant_if, or in any cycle with if_req_valid low.
- Reset during an in-flight access: the response is dropped and no rsp_valid is produced after reset deasserts.
- Misaligned addresses are not checked; the low address bits are ignored at the SRAM and the strobe defines the lanes.

Decomposition:
- Package mem_arb_pkg:
  - owner encoding typedef (NONE = 2'b00, IF = 2'b01, D = 2'b10);
  - STRB_W = DATA_W/8;
  - word-align mask constant.
- One natural sub-module, arb_starve_counter:
  - saturating counter with a clear input;
  - outputs the force-IF flag;
  - parameterised by MAX_STARVE.

Test Plan:
1. IF-only, addresses 0x0 then 0x4 on consecutive cycles, SRAM preloaded 0x11, 0x22 → if_req_ready is 1 both cycles; if_rsp_valid is 1 on cycles N+1 and N+2 with data 0x11 then 0x22.
2. IF and D load both valid at cycle N (D addr 0x40 = 0xCAFE0000) → d_req_ready = 1 and if_req_ready = 0 at N; d_rsp_data = 0xCAFE0000 at N+1; IF is granted at N+1.
3. MAX_STARVE = 4, D and IF valid continuously → grants are D,D,D,D,IF,D,…; starve_cnt returns to 0 after the IF grant.
4. D store to 0x102, strb 4'b1100, wdata 0xAABBAABB → sram_we = 4'b1100, sram_addr = 0x100; d_rsp_valid = 1 with d_rsp_data = 0 next cycle; a later load from 0x100 returns 0xAABB in the upper half with the lower half unchanged.
5. IF granted at N, if_flush at N, new IF granted at N+1 → no if_rsp_valid at N+1; if_rsp_valid = 1 at N+2 with the new fetch's data.
6. rst_n low for 1 cycle while a D load is in flight → no d_rsp_valid after reset; busy = 0; starve_cnt = 0.
